// File: rtl/pipe_pkg.sv
// Shared constants for the EXE stage: ALU control codes, multiplier FSM encoding, widths.
// No logic, no latency; nothing here applies backpressure.
package pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 5;
  localparam logic [4:0] RN_LINK = 5'd31;

  // Canonical encodings; ADD..LUI ignore bit 3 in the ALU decode
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/pipe_exe_mul_if.sv
// D/E-register inputs and E/M-register outputs of the EXE stage.
// master drives the instruction fields, slave (the stage) returns results and estall.
interface pipe_exe_mul_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [3:0]       ealuc;
  logic             ealuimm;
  logic             eshift;
  logic             ejal;
  logic             emul;
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] eb;
  logic [WIDTH-1:0] eimm;
  logic [WIDTH-1:0] epc4;
  logic             ewreg_i;
  logic             em2reg_i;
  logic             ewmem_i;
  logic [4:0]       ern0;

  logic             ewreg;
  logic             em2reg;
  logic             ewmem;
  logic [WIDTH-1:0] ealu;
  logic [WIDTH-1:0] eb_o;
  logic [4:0]       ern;
  logic             estall;

  modport master (
    output ealuc, ealuimm, eshift, ejal, emul, ea, eb, eimm, epc4,
           ewreg_i, em2reg_i, ewmem_i, ern0,
    input  ewreg, em2reg, ewmem, ealu, eb_o, ern, estall
  );

  modport slave (
    input  ealuc, ealuimm, eshift, ejal, emul, ea, eb, eimm, epc4,
           ewreg_i, em2reg_i, ewmem_i, ern0,
    output ewreg, em2reg, ewmem, ealu, eb_o, ern, estall
  );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier (low WIDTH bits of a*b): load edge, 2**CNT_W add steps, one DONE cycle.
// start is honoured only in IDLE; operands are captured once at load and never re-read.
module mul_iter
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mul_state_t       r_state;
  mul_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= MUL_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      MUL_IDLE: begin
        if (start) w_next = MUL_BUSY;
      end
      MUL_BUSY: begin
        busy = 1'b1;
        if (r_cnt == LAST) w_next = MUL_DONE;
      end
      MUL_DONE: begin
        done   = 1'b1;
        w_next = MUL_IDLE;
      end
      default: w_next = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (r_state == MUL_IDLE && start) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= a;
      r_mplier <= b;
    end else if (r_state == MUL_BUSY) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign product = r_acc;

endmodule

// File: rtl/pipe_exe_mul.sv
// EXE stage: single-cycle ALU/shift/JAL result, or a MUL that holds estall for 33 cycles then presents its product.
// Combinational outputs; while estall is high the E/M controls are forced to a bubble.
module pipe_exe_mul
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic          clock,
  input  logic          resetn,
  pipe_exe_mul_if.slave bus
);

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_product;
  logic             w_busy;
  logic             w_done;
  logic             w_stall;

  assign w_a = bus.eshift  ? WIDTH'(bus.eimm[10:6]) : bus.ea;
  assign w_b = bus.ealuimm ? bus.eimm               : bus.eb;

  always_comb begin
    w_alu = '0;
    casez (bus.ealuc)
      4'b?000: w_alu = w_a + w_b;
      4'b?100: w_alu = w_a - w_b;
      4'b?001: w_alu = w_a & w_b;
      4'b?101: w_alu = w_a | w_b;
      4'b?010: w_alu = w_a ^ w_b;
      4'b?110: w_alu = w_b << 16;
      4'b0011: w_alu = w_b << w_a[CNT_W-1:0];
      4'b0111: w_alu = w_b >> w_a[CNT_W-1:0];
      4'b1111: w_alu = $signed(w_b) >>> w_a[CNT_W-1:0];
      default: w_alu = '0;
    endcase
  end

  mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clock   (clock),
    .resetn  (resetn),
    .start   (bus.emul),
    .a       (bus.ea),
    .b       (bus.eb),
    .busy    (w_busy),
    .done    (w_done),
    .product (w_product)
  );

  // A MUL stalls from the cycle it arrives in IDLE until the multiplier reaches DONE
  assign w_stall = (bus.emul & ~w_busy & ~w_done) | w_busy;

  assign bus.estall = w_stall;
  assign bus.ewreg  = bus.ewreg_i  & ~w_stall;
  assign bus.em2reg = bus.em2reg_i & ~w_stall;
  assign bus.ewmem  = bus.ewmem_i  & ~w_stall;
  assign bus.eb_o   = bus.eb;
  assign bus.ern    = bus.ern0 | {5{bus.ejal}};
  assign bus.ealu   = bus.ejal ? bus.epc4 + WIDTH'(4) :
                      bus.emul ? w_product : w_alu;

endmodule

// File: tb/tb_pipe_exe_mul.sv
// Scoreboarded bench for pipe_exe_mul: each issued instruction pushes its expected result, popped when estall drops.
module tb_pipe_exe_mul;
  import pipe_pkg::*;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rn;
    logic [2:0]  ctl;
    logic [31:0] st;
    int          stalls;
  } exp_t;

  logic clock;
  logic resetn;
  int   n_chk;
  int   n_pass;
  exp_t sb[$];

  pipe_exe_mul_if #(.WIDTH(32)) bus ();

  pipe_exe_mul #(.WIDTH(32), .CNT_W(5)) u_dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic drive(input logic [3:0] aluc, input logic aluimm, input logic shift,
                       input logic jal, input logic mul, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc4,
                       input logic [2:0] ctl, input logic [4:0] rn);
    bus.ealuc    = aluc;
    bus.ealuimm  = aluimm;
    bus.eshift   = shift;
    bus.ejal     = jal;
    bus.emul     = mul;
    bus.ea       = a;
    bus.eb       = b;
    bus.eimm     = imm;
    bus.epc4     = pc4;
    bus.ewreg_i  = ctl[2];
    bus.em2reg_i = ctl[1];
    bus.ewmem_i  = ctl[0];
    bus.ern0     = rn;
  endtask

  task automatic issue(input string tag, input logic [3:0] aluc, input logic aluimm,
                       input logic shift, input logic jal, input logic mul,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] pc4, input logic [2:0] ctl, input logic [4:0] rn,
                       input logic [31:0] exp_alu, input logic [4:0] exp_rn, input int exp_stalls);
    exp_t e;
    int   stalls;
    bit   bad;
    bit   seen;
    drive(aluc, aluimm, shift, jal, mul, a, b, imm, pc4, ctl, rn);
    e.alu = exp_alu; e.rn = exp_rn; e.ctl = ctl; e.st = b; e.stalls = exp_stalls;
    sb.push_back(e);
    stalls = 0; bad = 0; seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clock);
      if (bus.estall) begin
        stalls++;
        if ({bus.ewreg, bus.em2reg, bus.ewmem} != 3'b000) bad = 1;
      end else begin
        seen = 1;
        e = sb.pop_front();
        chk({tag, "_alu"}, bus.ealu, e.alu);
        chk({tag, "_rn"}, 32'(bus.ern), 32'(e.rn));
        chk({tag, "_ctl"}, 32'({bus.ewreg, bus.em2reg, bus.ewmem}), 32'(e.ctl));
        chk({tag, "_st"}, bus.eb_o, e.st);
        chk({tag, "_stalls"}, 32'(stalls), 32'(e.stalls));
      end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'(stalls), 32'(exp_stalls));
      void'(sb.pop_front());
    end
    if (exp_stalls > 0) chk({tag, "_bubble"}, 32'(bad), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    n_chk = 0;
    n_pass = 0;
    resetn = 1'b0;
    drive(ALUC_ADD, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b100, 5'd1);
    @(negedge clock);
    chk("rst_estall", 32'(bus.estall), 32'd0);
    chk("rst_ewreg", 32'(bus.ewreg), 32'd1);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    issue("add",   ALUC_ADD, 0, 0, 0, 0, 32'd5, 32'd7, 32'd0, 32'd0, 3'b100, 5'd3, 32'd12, 5'd3, 0);
    issue("mul67", ALUC_ADD, 0, 0, 0, 1, 32'd6, 32'd7, 32'd0, 32'd0, 3'b111, 5'd4, 32'd42, 5'd4, 33);
    issue("mulneg", ALUC_ADD, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 3'b100, 5'd5,
          32'hFFFF_FFFE, 5'd5, 33);
    issue("mulovf", ALUC_ADD, 0, 0, 0, 1, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 3'b100, 5'd6,
          32'h0, 5'd6, 33);

    // Reset in the middle of a MUL
    drive(ALUC_ADD, 0, 0, 0, 1, 32'd9, 32'd9, 32'd0, 32'd0, 3'b100, 5'd7);
    repeat (11) @(posedge clock);
    #3;
    chk("pre_rst_estall", 32'(bus.estall), 32'd1);
    resetn = 1'b0;
    bus.emul = 1'b0;
    #1;
    chk("mid_rst_estall", 32'(bus.estall), 32'd0);
    chk("mid_rst_ewreg", 32'(bus.ewreg), 32'd1);
    chk("mid_rst_state", 32'(u_dut.u_mul.r_state), 32'(MUL_IDLE));
    chk("mid_rst_acc", u_dut.u_mul.r_acc, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    issue("mulpost", ALUC_ADD, 0, 0, 0, 1, 32'd6, 32'd7, 32'd0, 32'd0, 3'b100, 5'd8, 32'd42, 5'd8, 33);

    issue("b2b0", ALUC_ADD, 0, 0, 0, 1, 32'd3, 32'd4, 32'd0, 32'd0, 3'b100, 5'd9, 32'd12, 5'd9, 33);
    issue("b2b1", ALUC_ADD, 0, 0, 0, 1, 32'd5, 32'd5, 32'd0, 32'd0, 3'b100, 5'd10, 32'd25, 5'd10, 33);

    issue("jal",  ALUC_ADD, 0, 0, 1, 0, 32'd1, 32'd2, 32'd0, 32'h100, 3'b100, 5'd0, 32'h104, 5'd31, 0);
    issue("sra",  ALUC_SRA, 0, 0, 0, 0, 32'd4, 32'h8000_0000, 32'd0, 32'd0, 3'b100, 5'd11,
          32'hF800_0000, 5'd11, 0);
    issue("srl",  ALUC_SRL, 0, 0, 0, 0, 32'd4, 32'h8000_0000, 32'd0, 32'd0, 3'b100, 5'd12,
          32'h0800_0000, 5'd12, 0);
    issue("sll",  ALUC_SLL, 0, 1, 0, 0, 32'd31, 32'd1, 32'h0000_00C0, 32'd0, 3'b100, 5'd13,
          32'd8, 5'd13, 0);
    issue("sub",  ALUC_SUB, 0, 0, 0, 0, 32'd5, 32'd7, 32'd0, 32'd0, 3'b100, 5'd14, 32'hFFFF_FFFE, 5'd14, 0);
    issue("and",  ALUC_AND, 0, 0, 0, 0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 3'b100, 5'd15, 32'hF000, 5'd15, 0);
    issue("or",   ALUC_OR,  0, 0, 0, 0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 3'b100, 5'd16, 32'hFFF0, 5'd16, 0);
    issue("xor",  ALUC_XOR, 0, 0, 0, 0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 3'b100, 5'd17, 32'h0FF0, 5'd17, 0);
    issue("lui",  ALUC_LUI, 1, 0, 0, 0, 32'd0, 32'd9, 32'h1234, 32'd0, 3'b100, 5'd18,
          32'h1234_0000, 5'd18, 0);
    issue("addx", 4'b1000,  0, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 3'b100, 5'd19, 32'd0, 5'd19, 0);
    issue("store", ALUC_ADD, 1, 0, 0, 0, 32'h1000, 32'hCAFE, 32'd8, 32'd0, 3'b001, 5'd20,
          32'h1008, 5'd20, 0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      issue("rmul", ALUC_ADD, 0, 0, 0, 1, ra, rb, 32'd0, 32'd0, 3'b110, 5'd21, ra * rb, 5'd21, 33);
      ra = $urandom;
      rb = $urandom;
      issue("radd", ALUC_ADD, 0, 0, 0, 0, ra, rb, 32'd0, 32'd0, 3'b100, 5'd22, ra + rb, 5'd22, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
